// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   - parity mode constants (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - TX FSM state encoding
//   - minimum legal baud divisor and bit-index counter width
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Smallest divisor honoured; requests below this are clamped up.
  localparam int unsigned MIN_DIV = 2;

  // Wide enough to index up to 9 data bits or 2 stop bits.
  localparam int unsigned BIT_IDX_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk_i   : clock (rising edge)
//   rst_i   : asynchronous active-high reset, flushes the FIFO
//   push_i  : write wdata_i (caller guarantees not full)
//   pop_i   : drop the head word (caller guarantees not empty)
//   wdata_i : write data
//   rdata_o : head word, valid whenever empty_o is low
//   count_o : number of stored words
//   full_o  : count_o == DEPTH
//   empty_o : count_o == 0
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Storage needs no reset: only words behind a valid count are ever read.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Buffered UART transmitter with configurable frame format.
//   Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
//   osc_clk        : system clock
//   rst            : asynchronous active-high reset; flushes FIFO, line goes high
//   i_Tx_Valid     : write request, accepted when o_Tx_Ready is also high
//   i_Tx_Data      : word to transmit
//   o_Tx_Ready     : FIFO not full
//   i_Clks_Per_Bit : clock cycles per bit, clamped to >= 2, sampled at pop
//   o_Tx_Serial    : serial line, idle high
//   o_Tx_Active    : high from pop through the last stop-bit cycle
//   o_Tx_Done      : one-cycle pulse after the last stop bit of each frame
//   o_Fifo_Count   : words currently queued
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          osc_clk,
  input  logic                          rst,
  input  logic                          i_Tx_Valid,
  input  logic [DATA_BITS-1:0]          i_Tx_Data,
  output logic                          o_Tx_Ready,
  input  logic [DIV_W-1:0]              i_Clks_Per_Bit,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  tx_state_e              state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [DIV_W-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   done_q, done_d;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic [DIV_W-1:0]       div_clamped;
  logic                   par_bit;
  logic                   bit_tick, last_data, last_stop, load;

  assign fifo_push = i_Tx_Valid && !fifo_full;
  assign fifo_pop  = load;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (osc_clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (i_Tx_Data),
    .rdata_o (fifo_rdata),
    .count_o (o_Fifo_Count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign div_clamped = (i_Clks_Per_Bit < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_Clks_Per_Bit;
  // Even parity is the XOR of the data; odd parity is its inverse.
  assign par_bit     = (^fifo_rdata) ^ (PARITY == PAR_ODD);

  assign bit_tick  = (clk_cnt_q == div_q - DIV_W'(1));
  assign last_data = (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1));
  assign last_stop = (bit_idx_q == BIT_IDX_W'(STOP_BITS - 1));

  // State and datapath registers.
  always_ff @(posedge osc_clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= DIV_W'(MIN_DIV);
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    done_d    = 1'b0;
    load      = 1'b0;

    if (state_q != StIdle) begin
      clk_cnt_d = bit_tick ? '0 : clk_cnt_q + DIV_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) load = 1'b1;
      end
      StStart: begin
        if (bit_tick) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (last_data) begin
            bit_idx_d = '0;
            state_d   = (PARITY != PAR_NONE) ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
      StParity: begin
        if (bit_tick) state_d = StStop;
      end
      StStop: begin
        if (bit_tick) begin
          if (last_stop) begin
            done_d = 1'b1;
            // Chain straight into the next start bit when more data waits.
            if (!fifo_empty) load = 1'b1;
            else             state_d = StIdle;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d   = StStart;
      shift_d   = fifo_rdata;
      div_d     = div_clamped;
      parity_d  = par_bit;
      clk_cnt_d = '0;
      bit_idx_d = '0;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    o_Tx_Serial = 1'b1;
    unique case (state_q)
      StStart:  o_Tx_Serial = 1'b0;
      StData:   o_Tx_Serial = shift_q[0];
      StParity: o_Tx_Serial = parity_q;
      default:  o_Tx_Serial = 1'b1;
    endcase
  end

  assign o_Tx_Active = (state_q != StIdle);
  assign o_Tx_Done   = done_q;
  assign o_Tx_Ready  = !fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: 8N1, 7E2 and 7O2 instances.
module tb_uart_tx_fifo_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 8N1 instance
  logic        a_valid = 1'b0;
  logic [7:0]  a_data  = '0;
  logic [15:0] a_div   = 16'd4;
  logic        a_ready, a_serial, a_active, a_done;
  logic [4:0]  a_count;

  // 7E2 instance
  logic        b_valid = 1'b0;
  logic [6:0]  b_data  = '0;
  logic [15:0] b_div   = 16'd3;
  logic        b_ready, b_serial, b_active, b_done;
  logic [4:0]  b_count;

  // 7O2 instance
  logic        c_valid = 1'b0;
  logic [6:0]  c_data  = '0;
  logic [15:0] c_div   = 16'd3;
  logic        c_ready, c_serial, c_active, c_done;
  logic [4:0]  c_count;

  uart_tx_fifo_param #(
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16), .DIV_W(16)
  ) dut_a (
    .osc_clk(clk), .rst(rst), .i_Tx_Valid(a_valid), .i_Tx_Data(a_data),
    .o_Tx_Ready(a_ready), .i_Clks_Per_Bit(a_div), .o_Tx_Serial(a_serial),
    .o_Tx_Active(a_active), .o_Tx_Done(a_done), .o_Fifo_Count(a_count)
  );

  uart_tx_fifo_param #(
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16), .DIV_W(16)
  ) dut_b (
    .osc_clk(clk), .rst(rst), .i_Tx_Valid(b_valid), .i_Tx_Data(b_data),
    .o_Tx_Ready(b_ready), .i_Clks_Per_Bit(b_div), .o_Tx_Serial(b_serial),
    .o_Tx_Active(b_active), .o_Tx_Done(b_done), .o_Fifo_Count(b_count)
  );

  uart_tx_fifo_param #(
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16), .DIV_W(16)
  ) dut_c (
    .osc_clk(clk), .rst(rst), .i_Tx_Valid(c_valid), .i_Tx_Data(c_data),
    .o_Tx_Ready(c_ready), .i_Clks_Per_Bit(c_div), .o_Tx_Serial(c_serial),
    .o_Tx_Active(c_active), .o_Tx_Done(c_done), .o_Fifo_Count(c_count)
  );

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  // Checks one whole 8N1 frame on dut_a, starting at the first start-bit cycle.
  // Returns positioned at the first cycle after the frame.
  task automatic frame_a(input logic [7:0] d, input int div, input logic done0,
                         input string name);
    logic [9:0] bits;
    int errs, first;
    logic got, want;
    bits  = {1'b1, d, 1'b0};
    errs  = 0;
    first = -1;
    got   = 1'b0;
    want  = 1'b0;
    for (int c = 0; c < 10 * div; c++) begin
      logic ew, ed;
      ew = bits[c / div];
      ed = (c == 0) ? done0 : 1'b0;
      if (a_serial !== ew || a_active !== 1'b1 || a_done !== ed) begin
        if (errs == 0) begin
          first = c;
          got   = a_serial;
          want  = ew;
        end
        errs++;
      end
      wait_edge();
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s: %0d bad cycles, first at %0d serial=%b want %b; want 0 bad",
               name, errs, first, got, want);
    end
  endtask

  task automatic write_a(input logic [7:0] d);
    a_valid = 1'b1;
    a_data  = d;
    wait_edge();
    a_valid = 1'b0;
  endtask

  task automatic check_end_a(input string name);
    total++;
    if (a_done !== 1'b1 || a_active !== 1'b0 || a_serial !== 1'b1) begin
      bad++;
      $display("FAIL %s: done=%b active=%b serial=%b want 1 0 1",
               name, a_done, a_active, a_serial);
    end
  endtask

  task automatic test_reset();
    repeat (3) wait_edge();
    total++; if (a_serial !== 1'b1) begin bad++; $display("FAIL rst_serial: got %b want 1", a_serial); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", a_ready); end
    total++; if (a_active !== 1'b0) begin bad++; $display("FAIL rst_active: got %b want 0", a_active); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", a_done); end
    total++; if (a_count !== 5'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", a_count); end
    total++; if (b_serial !== 1'b1) begin bad++; $display("FAIL rst_serial_b: got %b want 1", b_serial); end
    rst = 1'b0;
    wait_edge();
  endtask

  task automatic test_8n1_basic();
    a_div = 16'd4;
    write_a(8'h55);
    total++; if (a_count !== 5'd1) begin bad++; $display("FAIL basic_count: got %0d want 1", a_count); end
    total++; if (a_serial !== 1'b1) begin bad++; $display("FAIL basic_prepop: got %b want 1", a_serial); end
    wait_edge();
    frame_a(8'h55, 4, 1'b0, "basic_frame");
    check_end_a("basic_end");
    wait_edge();
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", a_done); end
    total++; if (a_count !== 5'd0) begin bad++; $display("FAIL basic_count_end: got %0d want 0", a_count); end
  endtask

  task automatic test_parity();
    logic [10:0] exp_b, exp_c;
    int eb, ec;
    // bit index == frame position: start, d0..d6, parity, stop, stop
    exp_b = 11'b1_1_0_1000001_0;
    exp_c = 11'b1_1_1_1000001_0;
    eb = 0;
    ec = 0;
    b_div = 16'd3;
    c_div = 16'd3;
    b_valid = 1'b1; b_data = 7'h41;
    c_valid = 1'b1; c_data = 7'h41;
    wait_edge();
    b_valid = 1'b0;
    c_valid = 1'b0;
    wait_edge();
    for (int cy = 0; cy < 33; cy++) begin
      if (b_serial !== exp_b[cy / 3] || b_done !== 1'b0 || b_active !== 1'b1) eb++;
      if (c_serial !== exp_c[cy / 3] || c_done !== 1'b0 || c_active !== 1'b1) ec++;
      wait_edge();
    end
    total++; if (eb != 0) begin bad++; $display("FAIL even_frame: %0d bad cycles want 0", eb); end
    total++; if (ec != 0) begin bad++; $display("FAIL odd_frame: %0d bad cycles want 0", ec); end
    total++;
    if (b_done !== 1'b1 || b_active !== 1'b0) begin
      bad++; $display("FAIL even_end: done=%b active=%b want 1 0", b_done, b_active);
    end
    total++;
    if (c_done !== 1'b1 || c_active !== 1'b0) begin
      bad++; $display("FAIL odd_end: done=%b active=%b want 1 0", c_done, c_active);
    end
    wait_edge();
  endtask

  task automatic test_back_to_back();
    a_div = 16'd10;
    fork
      begin
        int n;
        for (int i = 1; i <= 17; i++) begin
          total++;
          if (a_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d: got %b want 1", i, a_ready); end
          a_valid = 1'b1;
          a_data  = 8'(i);
          wait_edge();
        end
        total++; if (a_count !== 5'd16) begin bad++; $display("FAIL b2b_full_count: got %0d want 16", a_count); end
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready: got %b want 0", a_ready); end
        a_data = 8'd18;
        n = 0;
        while (a_ready !== 1'b1 && n < 200) begin
          wait_edge();
          n++;
        end
        total++; if (n != 85) begin bad++; $display("FAIL b2b_hold_cycles: got %0d want 85", n); end
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL b2b_hold_done: got %b want 1", a_done); end
        wait_edge();
        a_valid = 1'b0;
        total++; if (a_count !== 5'd16) begin bad++; $display("FAIL b2b_18_count: got %0d want 16", a_count); end
      end
      begin
        wait_edge();
        wait_edge();
        for (int f = 1; f <= 18; f++) begin
          frame_a(8'(f), 10, (f > 1), $sformatf("b2b_frame_%0d", f));
        end
        check_end_a("b2b_end");
      end
    join
    wait_edge();
  endtask

  task automatic test_div_change();
    a_div = 16'd4;
    fork
      begin
        a_valid = 1'b1;
        a_data  = 8'hA5;
        wait_edge();
        a_data  = 8'h3C;
        wait_edge();
        a_valid = 1'b0;
        repeat (10) wait_edge();
        a_div = 16'd8;
      end
      begin
        wait_edge();
        wait_edge();
        frame_a(8'hA5, 4, 1'b0, "divchg_frame1");
        frame_a(8'h3C, 8, 1'b1, "divchg_frame2");
        check_end_a("divchg_end");
      end
    join
    wait_edge();
  endtask

  task automatic test_clamp();
    a_div = 16'd0;
    write_a(8'h0F);
    wait_edge();
    frame_a(8'h0F, 2, 1'b0, "clamp0_frame");
    check_end_a("clamp0_end");
    a_div = 16'd1;
    write_a(8'hF0);
    wait_edge();
    frame_a(8'hF0, 2, 1'b0, "clamp1_frame");
    check_end_a("clamp1_end");
    wait_edge();
  endtask

  task automatic test_reset_mid();
    logic [7:0] words [6];
    int errs;
    words[0] = 8'hF7; words[1] = 8'h11; words[2] = 8'h22;
    words[3] = 8'h33; words[4] = 8'h44; words[5] = 8'h55;
    a_div = 16'd4;
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1;
      a_data  = words[i];
      wait_edge();
    end
    a_valid = 1'b0;
    repeat (13) wait_edge();
    // Now inside data bit 3 of 0xF7, which is 0.
    total++; if (a_serial !== 1'b0) begin bad++; $display("FAIL rmid_pre_serial: got %b want 0", a_serial); end
    total++; if (a_count !== 5'd5) begin bad++; $display("FAIL rmid_pre_count: got %0d want 5", a_count); end
    #3;
    rst = 1'b1;
    #1;
    total++; if (a_serial !== 1'b1) begin bad++; $display("FAIL rmid_serial: got %b want 1", a_serial); end
    total++; if (a_count !== 5'd0) begin bad++; $display("FAIL rmid_count: got %0d want 0", a_count); end
    total++; if (a_active !== 1'b0) begin bad++; $display("FAIL rmid_active: got %b want 0", a_active); end
    repeat (3) wait_edge();
    rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_done !== 1'b0 || a_serial !== 1'b1 || a_active !== 1'b0) errs++;
      wait_edge();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL rmid_quiet: %0d bad cycles want 0", errs); end
    write_a(8'hC3);
    wait_edge();
    frame_a(8'hC3, 4, 1'b0, "rmid_after_frame");
    check_end_a("rmid_after_end");
    wait_edge();
  endtask

  initial begin
    test_reset();
    test_8n1_basic();
    test_parity();
    test_back_to_back();
    test_div_change();
    test_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
